// File: rtl/clock_pkg.sv
// Shared constants for the time/date counter: field indices, widths,
// wrap limits, reset values and the Gregorian leap-year helper.
package clock_pkg;

    // Bit positions of each field inside the adjust select vector
    localparam int FLD_SEC     = 0;
    localparam int FLD_MIN     = 1;
    localparam int FLD_HOUR    = 2;
    localparam int FLD_DAY     = 3;
    localparam int FLD_MONTH   = 4;
    localparam int FLD_YEAR    = 5;
    localparam int FLD_CENTURY = 6;
    localparam int NUM_FIELDS  = 7;

    // Field widths
    localparam int W_SEC     = 6;
    localparam int W_MIN     = 6;
    localparam int W_HOUR    = 5;
    localparam int W_DAY     = 5;
    localparam int W_MONTH   = 4;
    localparam int W_YEAR    = 7;
    localparam int W_CENTURY = 7;

    // Highest legal value of each fixed-range field (day depends on the date)
    localparam logic [W_SEC-1:0]     SEC_MAX     = 6'd59;
    localparam logic [W_MIN-1:0]     MIN_MAX     = 6'd59;
    localparam logic [W_HOUR-1:0]    HOUR_MAX    = 5'd23;
    localparam logic [W_MONTH-1:0]   MONTH_MAX   = 4'd12;
    localparam logic [W_YEAR-1:0]    YEAR_MAX    = 7'd99;
    localparam logic [W_CENTURY-1:0] CENTURY_MAX = 7'd99;

    // Day and month are one-based
    localparam logic [W_DAY-1:0]   DAY_RESET   = 5'd1;
    localparam logic [W_MONTH-1:0] MONTH_RESET = 4'd1;

    // Year 00 of a century is leap only when the century is divisible by 4
    function automatic logic is_leap(input logic [W_YEAR-1:0] year,
                                     input logic [W_CENTURY-1:0] century);
        if (year != '0)
            return (year[1:0] == 2'b00);
        else
            return (century[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/clock_days_in_month.sv
// Combinational month-length lookup including the leap-year February.
module clock_days_in_month
    import clock_pkg::*;
(
    input  logic [W_MONTH-1:0]   month,
    input  logic [W_YEAR-1:0]    year,
    input  logic [W_CENTURY-1:0] century,
    output logic [W_DAY-1:0]     max_day
);

    // Thirty days hath September, April, June and November
    always_comb begin
        max_day = 5'd31;
        case (month)
            4'd4, 4'd6, 4'd9, 4'd11: max_day = 5'd30;
            4'd2:                    max_day = is_leap(year, century) ? 5'd29 : 5'd28;
            default:                 max_day = 5'd31;
        endcase
    end

endmodule

// File: rtl/time_date_counter.sv
// Time/date register set with a one-second prescaler and full carry chain
// in run mode, and per-field carry-free increments in adjust mode.
module time_date_counter
    import clock_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int RESET_CENTURY = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_pulse_1s,
    input  logic [NUM_FIELDS-1:0] enable_cnt,
    input  logic                  inc_pulse,
    output logic [W_SEC-1:0]      sec,
    output logic [W_MIN-1:0]      min,
    output logic [W_HOUR-1:0]     hour,
    output logic [W_DAY-1:0]      day,
    output logic [W_MONTH-1:0]    month,
    output logic [W_YEAR-1:0]     year,
    output logic [W_CENTURY-1:0]  century,
    output logic                  tick_1s
);

    localparam int              PW       = $clog2(CLK_HZ);
    localparam logic [PW-1:0]   PRESC_TC = PW'(CLK_HZ - 1);
    localparam logic [W_CENTURY-1:0] CENTURY_RESET = W_CENTURY'(RESET_CENTURY);

    logic [PW-1:0]        presc_reg,   presc_next;
    logic                 tick_reg,    tick_next;
    logic [W_SEC-1:0]     sec_reg,     sec_next;
    logic [W_MIN-1:0]     min_reg,     min_next;
    logic [W_HOUR-1:0]    hour_reg,    hour_next;
    logic [W_DAY-1:0]     day_reg,     day_next,   day_pre;
    logic [W_MONTH-1:0]   month_reg,   month_next;
    logic [W_YEAR-1:0]    year_reg,    year_next;
    logic [W_CENTURY-1:0] century_reg, century_next;

    logic [W_DAY-1:0]      max_day_cur;
    logic [W_DAY-1:0]      max_day_next;
    logic [NUM_FIELDS-1:0] adj_inc;
    logic                  adjust_mode;
    logic                  run_mode;

    assign adjust_mode = (enable_cnt != '0);
    assign run_mode    = !adjust_mode && enable_pulse_1s;

    // Per-field increment strobes; a set select bit already implies adjust mode
    generate
        for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_adj
            assign adj_inc[gi] = inc_pulse & enable_cnt[gi];
        end
    endgenerate

    // Month length of the date currently held, for the day wrap decision
    clock_days_in_month u_dim_cur (
        .month   (month_reg),
        .year    (year_reg),
        .century (century_reg),
        .max_day (max_day_cur)
    );

    // Month length of the date about to be written, for the day clamp
    clock_days_in_month u_dim_next (
        .month   (month_next),
        .year    (year_next),
        .century (century_next),
        .max_day (max_day_next)
    );

    // Prescaler, second carry chain and adjust increments (day before clamp)
    always_comb begin
        presc_next   = '0;
        tick_next    = 1'b0;
        sec_next     = sec_reg;
        min_next     = min_reg;
        hour_next    = hour_reg;
        day_pre      = day_reg;
        month_next   = month_reg;
        year_next    = year_reg;
        century_next = century_reg;

        if (run_mode) begin
            if (presc_reg == PRESC_TC) begin
                presc_next = '0;
                tick_next  = 1'b1;
                if (sec_reg != SEC_MAX) begin
                    sec_next = sec_reg + 1'b1;
                end else begin
                    sec_next = '0;
                    if (min_reg != MIN_MAX) begin
                        min_next = min_reg + 1'b1;
                    end else begin
                        min_next = '0;
                        if (hour_reg != HOUR_MAX) begin
                            hour_next = hour_reg + 1'b1;
                        end else begin
                            hour_next = '0;
                            if (day_reg < max_day_cur) begin
                                day_pre = day_reg + 1'b1;
                            end else begin
                                day_pre = DAY_RESET;
                                if (month_reg != MONTH_MAX) begin
                                    month_next = month_reg + 1'b1;
                                end else begin
                                    month_next = MONTH_RESET;
                                    if (year_reg != YEAR_MAX) begin
                                        year_next = year_reg + 1'b1;
                                    end else begin
                                        year_next    = '0;
                                        century_next = (century_reg == CENTURY_MAX) ?
                                                       '0 : century_reg + 1'b1;
                                    end
                                end
                            end
                        end
                    end
                end
            end else begin
                presc_next = presc_reg + 1'b1;
            end
        end else begin
            if (adj_inc[FLD_SEC])
                sec_next = (sec_reg == SEC_MAX) ? '0 : sec_reg + 1'b1;
            if (adj_inc[FLD_MIN])
                min_next = (min_reg == MIN_MAX) ? '0 : min_reg + 1'b1;
            if (adj_inc[FLD_HOUR])
                hour_next = (hour_reg == HOUR_MAX) ? '0 : hour_reg + 1'b1;
            if (adj_inc[FLD_DAY])
                day_pre = (day_reg >= max_day_cur) ? DAY_RESET : day_reg + 1'b1;
            if (adj_inc[FLD_MONTH])
                month_next = (month_reg == MONTH_MAX) ? MONTH_RESET : month_reg + 1'b1;
            if (adj_inc[FLD_YEAR])
                year_next = (year_reg == YEAR_MAX) ? '0 : year_reg + 1'b1;
            if (adj_inc[FLD_CENTURY])
                century_next = (century_reg == CENTURY_MAX) ? '0 : century_reg + 1'b1;
        end
    end

    // Pull the day down to the last day of the resulting month if it overshoots
    assign day_next = (day_pre > max_day_next) ? max_day_next : day_pre;

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg   <= '0;
            tick_reg    <= 1'b0;
            sec_reg     <= '0;
            min_reg     <= '0;
            hour_reg    <= '0;
            day_reg     <= DAY_RESET;
            month_reg   <= MONTH_RESET;
            year_reg    <= '0;
            century_reg <= CENTURY_RESET;
        end else begin
            presc_reg   <= presc_next;
            tick_reg    <= tick_next;
            sec_reg     <= sec_next;
            min_reg     <= min_next;
            hour_reg    <= hour_next;
            day_reg     <= day_next;
            month_reg   <= month_next;
            year_reg    <= year_next;
            century_reg <= century_next;
        end
    end

    assign sec     = sec_reg;
    assign min     = min_reg;
    assign hour    = hour_reg;
    assign day     = day_reg;
    assign month   = month_reg;
    assign year    = year_reg;
    assign century = century_reg;
    assign tick_1s = tick_reg;

endmodule

// File: tb/tb_time_date_counter.sv
// Directed bench for time_date_counter with CLK_HZ=4; expected snapshots are
// queued as stimulus is applied and compared one clock later.
module tb_time_date_counter;

    localparam int CLK_HZ = 4;
    localparam int RC     = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable_pulse_1s;
    logic [6:0] enable_cnt;
    logic       inc_pulse;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [4:0] day;
    logic [3:0] month;
    logic [6:0] year;
    logic [6:0] century;
    logic       tick_1s;

    typedef struct packed {
        logic [5:0] sec;
        logic [5:0] min;
        logic [4:0] hour;
        logic [4:0] day;
        logic [3:0] month;
        logic [6:0] year;
        logic [6:0] century;
        logic       tick;
    } snap_t;

    typedef struct {
        string tag;
        snap_t exp;
    } sb_t;

    sb_t sb_q[$];
    int  checks   = 0;
    int  failures = 0;

    time_date_counter #(.CLK_HZ(CLK_HZ), .RESET_CENTURY(RC)) dut (
        .clk             (clk),
        .rst             (rst),
        .enable_pulse_1s (enable_pulse_1s),
        .enable_cnt      (enable_cnt),
        .inc_pulse       (inc_pulse),
        .sec             (sec),
        .min             (min),
        .hour            (hour),
        .day             (day),
        .month           (month),
        .year            (year),
        .century         (century),
        .tick_1s         (tick_1s)
    );

    always #5 clk = ~clk;

    function automatic snap_t st(input int s, input int mi, input int h, input int d,
                                 input int mo, input int y, input int c, input int t);
        snap_t r;
        r.sec     = 6'(s);
        r.min     = 6'(mi);
        r.hour    = 5'(h);
        r.day     = 5'(d);
        r.month   = 4'(mo);
        r.year    = 7'(y);
        r.century = 7'(c);
        r.tick    = 1'(t);
        return r;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_pop();
        sb_t   e;
        snap_t act;
        act = {sec, min, hour, day, month, year, century, tick_1s};
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: observed no entry, required one entry");
        end else begin
            e = sb_q.pop_front();
            assert (act === e.exp) else begin
                failures++;
                $error("FAIL %s: observed s=%0d m=%0d h=%0d d=%0d mo=%0d y=%0d c=%0d t=%0b expected s=%0d m=%0d h=%0d d=%0d mo=%0d y=%0d c=%0d t=%0b",
                       e.tag, act.sec, act.min, act.hour, act.day, act.month, act.year,
                       act.century, act.tick, e.exp.sec, e.exp.min, e.exp.hour, e.exp.day,
                       e.exp.month, e.exp.year, e.exp.century, e.exp.tick);
            end
            $display("txn %0d %s: %0d%02d-%02d-%02d %02d:%02d:%02d tick=%0b", checks, e.tag,
                     century, year, month, day, hour, min, sec, tick_1s);
        end
    endtask

    // Queue the expectation with the current stimulus, clock once, compare
    task automatic step_exp(input string tag, input snap_t e);
        sb_t item;
        item.tag = tag;
        item.exp = e;
        sb_q.push_back(item);
        step(1);
        check_pop();
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        enable_cnt = '0;
        inc_pulse  = 1'b0;
        step_exp("reset", st(0, 0, 0, 1, 1, 0, RC, 0));
        rst = 1'b0;
    endtask

    task automatic pulses(input logic [6:0] mask, input int n);
        if (n > 0) begin
            enable_cnt = mask;
            inc_pulse  = 1'b1;
            step(n);
            inc_pulse  = 1'b0;
            enable_cnt = '0;
        end
    endtask

    // Walk every field up from its reset value to the requested value
    task automatic preload(input int s, input int mi, input int h, input int d,
                           input int mo, input int y, input int c);
        pulses(7'b1000000, (c - RC + 100) % 100);
        pulses(7'b0100000, y);
        pulses(7'b0010000, mo - 1);
        pulses(7'b0001000, d - 1);
        pulses(7'b0000100, h);
        pulses(7'b0000010, mi);
        pulses(7'b0000001, s);
    endtask

    task automatic run_second(input string tag, input snap_t pre, input snap_t post);
        enable_cnt      = '0;
        enable_pulse_1s = 1'b1;
        for (int i = 1; i < CLK_HZ; i++) step_exp({tag, "_wait"}, pre);
        step_exp(tag, post);
        enable_pulse_1s = 1'b0;
    endtask

    task automatic leap_case(input string tag, input int y, input int c,
                             input int exp_day, input int exp_month);
        do_reset();
        preload(59, 59, 23, 28, 2, y, c);
        run_second(tag, st(59, 59, 23, 28, 2, y, c, 0),
                   st(0, 0, 0, exp_day, exp_month, y, c, 1));
    endtask

    initial begin
        rst             = 1'b1;
        enable_pulse_1s = 1'b0;
        enable_cnt      = '0;
        inc_pulse       = 1'b0;

        // Basic run: ticks every CLK_HZ cycles
        do_reset();
        enable_pulse_1s = 1'b1;
        for (int c = 1; c <= 16; c++)
            step_exp("run", st(c / 4, 0, 0, 1, 1, 0, RC, (c % 4 == 0) ? 1 : 0));

        // Idle: fields hold and increments are ignored
        enable_pulse_1s = 1'b0;
        inc_pulse       = 1'b1;
        step_exp("idle_hold", st(4, 0, 0, 1, 1, 0, RC, 0));
        step_exp("idle_hold", st(4, 0, 0, 1, 1, 0, RC, 0));
        inc_pulse = 1'b0;

        // Full rollover 2099-12-31 23:59:59 -> 2100-01-01 00:00:00
        do_reset();
        preload(59, 59, 23, 31, 12, 99, 20);
        run_second("rollover", st(59, 59, 23, 31, 12, 99, 20, 0),
                   st(0, 0, 0, 1, 1, 0, 21, 1));

        // Leap-year handling across Feb 28
        leap_case("leap_y24", 24, 20, 29, 2);
        leap_case("leap_y23", 23, 20, 1, 3);
        leap_case("leap_y00_c20", 0, 20, 29, 2);
        leap_case("leap_y00_c21", 0, 21, 1, 3);

        // Day clamp on month change, then day wrap at Feb 28
        do_reset();
        preload(0, 0, 0, 31, 1, 23, 20);
        step_exp("clamp_pre", st(0, 0, 0, 31, 1, 23, 20, 0));
        enable_cnt = 7'b0010000;
        inc_pulse  = 1'b1;
        step_exp("clamp_month", st(0, 0, 0, 28, 2, 23, 20, 0));
        enable_cnt = 7'b0001000;
        step_exp("day_wrap_feb", st(0, 0, 0, 1, 2, 23, 20, 0));
        inc_pulse  = 1'b0;
        enable_cnt = '0;

        // Multi-field adjust without carry, run enable held high throughout
        do_reset();
        enable_pulse_1s = 1'b1;
        preload(59, 59, 5, 1, 1, 0, 20);
        enable_cnt = 7'b0000011;
        inc_pulse  = 1'b1;
        step_exp("multi_adj", st(0, 0, 5, 1, 1, 0, RC, 0));
        inc_pulse = 1'b0;
        for (int i = 0; i < 6; i++)
            step_exp("adj_no_tick", st(0, 0, 5, 1, 1, 0, RC, 0));

        // Leaving adjust: a full second before the next tick
        enable_cnt = '0;
        for (int i = 1; i < CLK_HZ; i++)
            step_exp("exit_adj_wait", st(0, 0, 5, 1, 1, 0, RC, 0));
        step_exp("exit_adj_tick", st(1, 0, 5, 1, 1, 0, RC, 1));

        // Reset in mid-second at prescaler == 2
        step_exp("pre_rst", st(1, 0, 5, 1, 1, 0, RC, 0));
        step_exp("pre_rst", st(1, 0, 5, 1, 1, 0, RC, 0));
        rst = 1'b1;
        step_exp("mid_run_rst", st(0, 0, 0, 1, 1, 0, RC, 0));
        rst = 1'b0;
        for (int i = 1; i < CLK_HZ; i++)
            step_exp("post_rst_wait", st(0, 0, 0, 1, 1, 0, RC, 0));
        step_exp("post_rst_tick", st(1, 0, 0, 1, 1, 0, RC, 1));
        enable_pulse_1s = 1'b0;

        checks++;
        assert (sb_q.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_drain: observed %0d entries, expected 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
